// File: rtl/fp_vec_pkg.sv
// Shared types and the operand/expected table for the FP vector runner.
package fp_vec_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StDrain,
      StDone
   } state_e;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   // Single-precision add vectors: {a, b, a + b}.
   localparam vec_t VecTable [16] = '{
      '{a: 32'h40C99999, b: 32'h40C99999, exp: 32'h41499999},  // 6.3 + 6.3
      '{a: 32'h3F800000, b: 32'h3F800000, exp: 32'h40000000},  // 1 + 1
      '{a: 32'h3F800000, b: 32'hBF800000, exp: 32'h00000000},  // 1 - 1
      '{a: 32'h00000000, b: 32'h40490FDB, exp: 32'h40490FDB},  // 0 + pi
      '{a: 32'h40000000, b: 32'h40400000, exp: 32'h40A00000},  // 2 + 3
      '{a: 32'h3F000000, b: 32'h3F000000, exp: 32'h3F800000},  // 0.5 + 0.5
      '{a: 32'h41200000, b: 32'hC0A00000, exp: 32'h40A00000},  // 10 - 5
      '{a: 32'h40800000, b: 32'h40800000, exp: 32'h41000000},  // 4 + 4
      '{a: 32'h3F800000, b: 32'h40000000, exp: 32'h40400000},  // 1 + 2
      '{a: 32'h42C80000, b: 32'h42C80000, exp: 32'h43480000},  // 100 + 100
      '{a: 32'hBF800000, b: 32'hBF800000, exp: 32'hC0000000},  // -1 - 1
      '{a: 32'h7F800000, b: 32'h3F800000, exp: 32'h7F800000},  // inf + 1
      '{a: 32'h3E800000, b: 32'h3E800000, exp: 32'h3F000000},  // 0.25 + 0.25
      '{a: 32'h40400000, b: 32'hC0400000, exp: 32'h00000000},  // 3 - 3
      '{a: 32'h41000000, b: 32'h41000000, exp: 32'h41800000},  // 8 + 8
      '{a: 32'h44800000, b: 32'h3F800000, exp: 32'h44802000}   // 1024 + 1
   };

endpackage

// File: rtl/fp_valid_pipe.sv
// Depth-stage shift register carrying {valid, idx} alongside the FP core latency.
module fp_valid_pipe #(
   parameter int unsigned Depth = 7
) (
   input  logic       clk_i,
   input  logic       clr_i,
   input  logic       vld_i,
   input  logic [3:0] idx_i,
   output logic       vld_o,
   output logic [3:0] idx_o,
   output logic       pending_o
);

   logic [Depth-1:0] vld_q;
   logic [3:0]       idx_q [Depth];

   // Shift valid/index one stage per cycle; synchronous clear empties the pipe.
   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         vld_q <= '0;
         for (int k = 0; k < Depth; k++) idx_q[k] <= '0;
      end else begin
         vld_q[0] <= vld_i;
         idx_q[0] <= idx_i;
         for (int k = 1; k < Depth; k++) begin
            vld_q[k] <= vld_q[k-1];
            idx_q[k] <= idx_q[k-1];
         end
      end
   end

   // Pending excludes the tail: the tail entry is being consumed this cycle.
   always_comb begin
      pending_o = 1'b0;
      for (int k = 0; k + 1 < Depth; k++) pending_o = pending_o | vld_q[k];
   end

   assign vld_o = vld_q[Depth-1];
   assign idx_o = idx_q[Depth-1];

endmodule

// File: rtl/fp_vector_runner.sv
// Streams the vector table into an FP core and scores the returned results.
module fp_vector_runner
   import fp_vec_pkg::*;
#(
   parameter int unsigned LATENCY     = 7,
   parameter int unsigned NUM_VECTORS = 8,
   localparam int unsigned CW         = $clog2(NUM_VECTORS + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic [31:0]   op_a,
   output logic [31:0]   op_b,
   input  logic [31:0]   ip_result,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] pass_count,
   output logic [CW-1:0] fail_count,
   output logic [3:0]    fail_index,
   output logic [31:0]   fail_value
);

   state_e        state_q, state_d;
   logic [3:0]    issue_idx_q, issue_idx_d;
   logic [31:0]   op_a_q, op_a_d, op_b_q, op_b_d;
   logic          op_vld_q, op_vld_d;
   logic [3:0]    op_idx_q, op_idx_d;
   logic [CW-1:0] pass_q, pass_d, fail_q, fail_d;
   logic [3:0]    fidx_q, fidx_d;
   logic [31:0]   fval_q, fval_d;
   logic          clr_cnt;
   logic          tail_vld, pending;
   logic [3:0]    tail_idx;

   // The pipe is fed from the operand register so its tail lines up with ip_result.
   fp_valid_pipe #(
      .Depth (LATENCY)
   ) u_pipe (
      .clk_i     (clk),
      .clr_i     (reset),
      .vld_i     (op_vld_q),
      .idx_i     (op_idx_q),
      .vld_o     (tail_vld),
      .idx_o     (tail_idx),
      .pending_o (pending)
   );

   // Run sequencing and operand selection.
   always_comb begin
      state_d     = state_q;
      issue_idx_d = issue_idx_q;
      op_a_d      = '0;
      op_b_d      = '0;
      op_vld_d    = 1'b0;
      op_idx_d    = '0;
      clr_cnt     = 1'b0;
      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d     = StIssue;
               issue_idx_d = '0;
               clr_cnt     = 1'b1;
            end
         end
         StIssue: begin
            op_a_d   = VecTable[issue_idx_q].a;
            op_b_d   = VecTable[issue_idx_q].b;
            op_vld_d = 1'b1;
            op_idx_d = issue_idx_q;
            if (issue_idx_q == 4'(NUM_VECTORS - 1)) state_d = StDrain;
            else issue_idx_d = issue_idx_q + 4'd1;
         end
         StDrain: begin
            if (!op_vld_q && !pending) state_d = StDone;
         end
         default: state_d = StIdle;
      endcase
   end

   // Result scoring with first-failure capture.
   always_comb begin
      pass_d = pass_q;
      fail_d = fail_q;
      fidx_d = fidx_q;
      fval_d = fval_q;
      if (clr_cnt) begin
         pass_d = '0;
         fail_d = '0;
         fidx_d = '0;
         fval_d = '0;
      end else if (tail_vld) begin
         if (ip_result == VecTable[tail_idx].exp) begin
            pass_d = pass_q + 1'b1;
         end else begin
            fail_d = fail_q + 1'b1;
            if (fail_q == '0) begin
               fidx_d = tail_idx;
               fval_d = ip_result;
            end
         end
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         issue_idx_q <= '0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         op_vld_q    <= 1'b0;
         op_idx_q    <= '0;
         pass_q      <= '0;
         fail_q      <= '0;
         fidx_q      <= '0;
         fval_q      <= '0;
      end else begin
         state_q     <= state_d;
         issue_idx_q <= issue_idx_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         op_vld_q    <= op_vld_d;
         op_idx_q    <= op_idx_d;
         pass_q      <= pass_d;
         fail_q      <= fail_d;
         fidx_q      <= fidx_d;
         fval_q      <= fval_d;
      end
   end

   assign op_a       = op_a_q;
   assign op_b       = op_b_q;
   assign busy       = (state_q == StIssue) || (state_q == StDrain);
   assign done       = (state_q == StDone);
   assign pass_count = pass_q;
   assign fail_count = fail_q;
   assign fail_index = fidx_q;
   assign fail_value = fval_q;

endmodule

// File: tb/tb_fp_vector_runner.sv
// Directed bench for fp_vector_runner with a delay-line model of the FP add core.
module tb_fp_vector_runner;

   localparam logic [31:0] TA [16] = '{
      32'h40C99999, 32'h3F800000, 32'h3F800000, 32'h00000000,
      32'h40000000, 32'h3F000000, 32'h41200000, 32'h40800000,
      32'h3F800000, 32'h42C80000, 32'hBF800000, 32'h7F800000,
      32'h3E800000, 32'h40400000, 32'h41000000, 32'h44800000};
   localparam logic [31:0] TB [16] = '{
      32'h40C99999, 32'h3F800000, 32'hBF800000, 32'h40490FDB,
      32'h40400000, 32'h3F000000, 32'hC0A00000, 32'h40800000,
      32'h40000000, 32'h42C80000, 32'hBF800000, 32'h3F800000,
      32'h3E800000, 32'hC0400000, 32'h41000000, 32'h3F800000};
   localparam logic [31:0] TE [16] = '{
      32'h41499999, 32'h40000000, 32'h00000000, 32'h40490FDB,
      32'h40A00000, 32'h3F800000, 32'h40A00000, 32'h41000000,
      32'h40400000, 32'h43480000, 32'hC0000000, 32'h7F800000,
      32'h3F000000, 32'h00000000, 32'h41800000, 32'h44802000};

   logic        clk = 1'b0;
   logic        reset, start_m, start_s;
   logic [15:0] corrupt;
   logic [31:0] cval;
   int          n_vec = 0;
   int          n_err = 0;

   logic [31:0] op_a_m, op_b_m, ip_m, fval_m;
   logic        busy_m, done_m;
   logic [3:0]  pass_m, fail_m, fidx_m;

   logic [31:0] op_a_1, op_b_1, ip_1, fval_1;
   logic        busy_1, done_1;
   logic [0:0]  pass_1, fail_1;
   logic [3:0]  fidx_1;

   logic [31:0] op_a_16, op_b_16, ip_16, fval_16;
   logic        busy_16, done_16;
   logic [0:0]  pass_16, fail_16;
   logic [3:0]  fidx_16;

   logic [31:0] dl_m [16];
   logic [31:0] dl_1 [16];
   logic [31:0] dl_16 [16];

   always #5 clk = ~clk;

   fp_vector_runner #(.LATENCY(7), .NUM_VECTORS(8)) dut (
      .clk (clk), .reset (reset), .start (start_m), .op_a (op_a_m), .op_b (op_b_m),
      .ip_result (ip_m), .busy (busy_m), .done (done_m), .pass_count (pass_m),
      .fail_count (fail_m), .fail_index (fidx_m), .fail_value (fval_m));

   fp_vector_runner #(.LATENCY(1), .NUM_VECTORS(1)) dut_l1 (
      .clk (clk), .reset (reset), .start (start_s), .op_a (op_a_1), .op_b (op_b_1),
      .ip_result (ip_1), .busy (busy_1), .done (done_1), .pass_count (pass_1),
      .fail_count (fail_1), .fail_index (fidx_1), .fail_value (fval_1));

   fp_vector_runner #(.LATENCY(16), .NUM_VECTORS(1)) dut_l16 (
      .clk (clk), .reset (reset), .start (start_s), .op_a (op_a_16), .op_b (op_b_16),
      .ip_result (ip_16), .busy (busy_16), .done (done_16), .pass_count (pass_16),
      .fail_count (fail_16), .fail_index (fidx_16), .fail_value (fval_16));

   // Core model: look the operand pair up in the bench table, optionally corrupt it.
   function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
      for (int i = 0; i < 16; i++) begin
         if (a == TA[i] && b == TB[i]) return corrupt[i] ? cval : TE[i];
      end
      return 32'h0;
   endfunction

   // Latency delay lines; tap LATENCY-1 gives the core output.
   always @(posedge clk) begin
      dl_m[0]  <= model(op_a_m, op_b_m);
      dl_1[0]  <= model(op_a_1, op_b_1);
      dl_16[0] <= model(op_a_16, op_b_16);
      for (int k = 1; k < 16; k++) begin
         dl_m[k]  <= dl_m[k-1];
         dl_1[k]  <= dl_1[k-1];
         dl_16[k] <= dl_16[k-1];
      end
   end

   assign ip_m  = dl_m[6];
   assign ip_1  = dl_1[0];
   assign ip_16 = dl_16[15];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_op_a"}, op_a_m, 32'h0);
      check({tag, "_op_b"}, op_b_m, 32'h0);
      check({tag, "_busy"}, 32'(busy_m), 32'd0);
      check({tag, "_done"}, 32'(done_m), 32'd0);
      check({tag, "_pass"}, 32'(pass_m), 32'd0);
      check({tag, "_fail"}, 32'(fail_m), 32'd0);
      check({tag, "_fidx"}, 32'(fidx_m), 32'd0);
      check({tag, "_fval"}, fval_m, 32'h0);
   endtask

   // One main run: start pulse, optional extra pulse at cycle pulse_at, wait for done.
   task automatic run_main(input int pulse_at, input bit chk_ops, output int cycles);
      start_m = 1'b1;
      tick();
      start_m = 1'b0;
      check("busy_after_start", 32'(busy_m), 32'd1);
      check("pass_cleared", 32'(pass_m), 32'd0);
      check("fail_cleared", 32'(fail_m), 32'd0);
      cycles = 0;
      while (cycles < 40) begin
         if (cycles == pulse_at) start_m = 1'b1;
         tick();
         start_m = 1'b0;
         cycles++;
         if (chk_ops && cycles <= 8) begin
            check("op_a_seq", op_a_m, TA[cycles-1]);
            check("op_b_seq", op_b_m, TB[cycles-1]);
         end
         if (cycles == pulse_at + 1) begin
            check("busy_after_drain_start", 32'(busy_m), 32'd1);
            check("done_after_drain_start", 32'(done_m), 32'd0);
         end
         if (done_m) break;
      end
   endtask

   initial begin
      int cyc;
      int c, c1, c16;
      reset   = 1'b1;
      start_m = 1'b0;
      start_s = 1'b0;
      corrupt = '0;
      cval    = '0;
      tick();
      tick();
      check_reset_state("reset");
      reset = 1'b0;
      tick();

      // All vectors pass.
      run_main(-1, 1'b1, cyc);
      check("allpass_cycles", 32'(cyc), 32'd16);
      check("allpass_busy", 32'(busy_m), 32'd0);
      check("allpass_pass", 32'(pass_m), 32'd8);
      check("allpass_fail", 32'(fail_m), 32'd0);
      tick();
      check("allpass_done_hold", 32'(done_m), 32'd1);

      // Single fault on vector 2; restart from DONE.
      corrupt = 16'h0004;
      cval    = 32'h3F800000;
      run_main(-1, 1'b0, cyc);
      check("single_cycles", 32'(cyc), 32'd16);
      check("single_pass", 32'(pass_m), 32'd7);
      check("single_fail", 32'(fail_m), 32'd1);
      check("single_fidx", 32'(fidx_m), 32'd2);
      check("single_fval", fval_m, 32'h3F800000);

      // Faults on vectors 5 and 6, plus an ignored start during DRAIN.
      corrupt = 16'h0060;
      cval    = 32'hDEADBEEF;
      run_main(10, 1'b0, cyc);
      check("multi_cycles", 32'(cyc), 32'd16);
      check("multi_pass", 32'(pass_m), 32'd6);
      check("multi_fail", 32'(fail_m), 32'd2);
      check("multi_fidx", 32'(fidx_m), 32'd5);
      check("multi_fval", fval_m, 32'hDEADBEEF);

      // Reset while vector 3 is being issued; late core results must be ignored.
      corrupt = '0;
      start_m = 1'b1;
      tick();
      start_m = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("midrun_op_a_vec3", op_a_m, TA[3]);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_reset_state("midrun_reset");
      for (int i = 0; i < 20; i++) tick();
      check("late_pass", 32'(pass_m), 32'd0);
      check("late_fail", 32'(fail_m), 32'd0);
      check("late_busy", 32'(busy_m), 32'd0);
      check("late_done", 32'(done_m), 32'd0);

      // Latency sweep with a single vector.
      start_s = 1'b1;
      tick();
      start_s = 1'b0;
      c   = 0;
      c1  = -1;
      c16 = -1;
      while (c < 40 && (c1 < 0 || c16 < 0)) begin
         tick();
         c++;
         if (done_1 && c1 < 0) c1 = c;
         if (done_16 && c16 < 0) c16 = c;
      end
      check("lat1_cycles", 32'(c1), 32'd3);
      check("lat16_cycles", 32'(c16), 32'd18);
      check("lat1_pass", 32'(pass_1), 32'd1);
      check("lat16_pass", 32'(pass_16), 32'd1);
      check("lat1_fail", 32'(fail_1), 32'd0);
      check("lat16_fail", 32'(fail_16), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
